// File: rtl/ce_strobe_pkg.sv
// ---------------------------------------------------------------------------
// ce_strobe_pkg
// Shared types and defaults for the clock-enable / clear strobe sequencer.
//   state_t      : sequencer FSM states (IDLE, CLEAR, RUN, DONE)
//   CNT_W_DEF    : default width of the strobe period counter
//   BURST_W_DEF  : default width of burst length and strobe index
// ---------------------------------------------------------------------------
package ce_strobe_pkg;

   localparam int unsigned CNT_W_DEF   = 16;
   localparam int unsigned BURST_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/ce_reload_counter.sv
// ---------------------------------------------------------------------------
// ce_reload_counter
// Down-counter with synchronous load, automatic reload when it reaches zero,
// and a zero flag.
// Ports:
//   clk_i         : clock
//   rst_i         : synchronous active-high reset (counter -> 0)
//   load_i        : load load_val_i this cycle (priority over run_i)
//   load_val_i    : value loaded by load_i
//   run_i         : count this cycle: decrement, or reload at zero
//   reload_val_i  : value taken when the count is zero and run_i is high
//   zero_o        : count currently equals zero
// ---------------------------------------------------------------------------
module ce_reload_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             run_i,
   input  logic [CNT_W-1:0] reload_val_i,
   output logic             zero_o
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign zero_o = (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (run_i) begin
         cnt_d = zero_o ? reload_val_i : (cnt_q - ONE);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ce_strobe_gen.sv
// ---------------------------------------------------------------------------
// ce_strobe_gen
// Strobe sequencer for enable-and-clear capture flops: on start it issues one
// clear pulse (cd), then a burst of single-cycle enable strobes (sp) every
// cfg_period+1 cycles, then a one-cycle done pulse.
// Optional feature macro: CE_STROBE_PHASE_EN adds cfg_phase, the counter
// value loaded for the first strobe (first sp at 2 + phase cycles after the
// start cycle).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   cfg_period   : strobe period minus one (P), latched at start
//   cfg_burst    : strobes per burst (B), 0 = continuous, latched at start
//   cfg_phase    : (CE_STROBE_PHASE_EN only) first-strobe counter load
//   start, stop  : begin / abort the sequence
//   sp, cd       : enable strobe, clear strobe (one-cycle pulses)
//   busy, done   : sequence in progress, one-cycle burst-complete pulse
//   strobe_idx   : number of sp pulses issued in the current/last sequence
// ---------------------------------------------------------------------------
module ce_strobe_gen
   import ce_strobe_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int BURST_W = BURST_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [CNT_W-1:0]   cfg_period,
   input  logic [BURST_W-1:0] cfg_burst,
`ifdef CE_STROBE_PHASE_EN
   input  logic [CNT_W-1:0]   cfg_phase,
`endif
   input  logic               start,
   input  logic               stop,
   output logic               sp,
   output logic               cd,
   output logic               busy,
   output logic               done,
   output logic [BURST_W-1:0] strobe_idx
);

   // Control handshake: start is a level sampled every cycle but only acts
   // in IDLE with stop low (stop wins); cfg_* are sampled only in that same
   // cycle. stop acts in CLEAR/RUN and returns to IDLE without done. There is
   // no back-pressure; busy tells the requester when start will be ignored.

   localparam logic [BURST_W-1:0] IDX_ONE = {{(BURST_W-1){1'b0}}, 1'b1};

   state_t             state_q,  state_d;
   logic [CNT_W-1:0]   period_q, period_d;
   logic [BURST_W-1:0] burst_q,  burst_d;
   logic [BURST_W-1:0] idx_q,    idx_d;
   logic [BURST_W-1:0] idx_inc;
   logic [CNT_W-1:0]   first_load;
   logic               cnt_load;
   logic               cnt_run;
   logic               cnt_zero;

`ifdef CE_STROBE_PHASE_EN
   logic [CNT_W-1:0]   phase_q, phase_d;
   assign first_load = phase_q;
`else
   assign first_load = period_q;
`endif

   assign idx_inc = idx_q + IDX_ONE;

   ce_reload_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk_i        (clk),
      .rst_i        (rst),
      .load_i       (cnt_load),
      .load_val_i   (first_load),
      .run_i        (cnt_run),
      .reload_val_i (period_q),
      .zero_o       (cnt_zero)
   );

   always_comb begin
      state_d  = state_q;
      period_d = period_q;
      burst_d  = burst_q;
      idx_d    = idx_q;
      cnt_load = 1'b0;
      cnt_run  = 1'b0;
`ifdef CE_STROBE_PHASE_EN
      phase_d  = phase_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start && !stop) begin
               state_d  = CLEAR;
               period_d = cfg_period;
               burst_d  = cfg_burst;
`ifdef CE_STROBE_PHASE_EN
               phase_d  = cfg_phase;
`endif
            end
         end
         CLEAR: begin
            cnt_load = 1'b1;
            idx_d    = '0;
            state_d  = stop ? IDLE : RUN;
         end
         RUN: begin
            cnt_run = 1'b1;
            // A strobe issued in the same cycle as stop still counts.
            if (cnt_zero) begin
               idx_d = idx_inc;
               if ((burst_q != '0) && (idx_inc == burst_q)) begin
                  state_d = DONE;
               end
            end
            if (stop) begin
               state_d = IDLE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         period_q <= '0;
         burst_q  <= '0;
         idx_q    <= '0;
`ifdef CE_STROBE_PHASE_EN
         phase_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         period_q <= period_d;
         burst_q  <= burst_d;
         idx_q    <= idx_d;
`ifdef CE_STROBE_PHASE_EN
         phase_q  <= phase_d;
`endif
      end
   end

   // Outputs depend only on registered state and the counter's zero flag.
   assign sp         = (state_q == RUN) && cnt_zero;
   assign cd         = (state_q == CLEAR);
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign strobe_idx = idx_q;

endmodule

// File: tb/tb_ce_strobe_gen.sv
module tb_ce_strobe_gen;

   localparam int CNT_W   = 16;
   localparam int BURST_W = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst;
   logic [CNT_W-1:0]   cfg_period;
   logic [BURST_W-1:0] cfg_burst;
   logic [CNT_W-1:0]   cfg_phase;
   logic               start;
   logic               stop;
   logic               sp, cd, busy, done;
   logic [BURST_W-1:0] strobe_idx;

   ce_strobe_gen #(
      .CNT_W   (CNT_W),
      .BURST_W (BURST_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_period (cfg_period),
      .cfg_burst  (cfg_burst),
`ifdef CE_STROBE_PHASE_EN
      .cfg_phase  (cfg_phase),
`endif
      .start      (start),
      .stop       (stop),
      .sp         (sp),
      .cd         (cd),
      .busy       (busy),
      .done       (done),
      .strobe_idx (strobe_idx)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int sp_log[$];
   logic [31:0] exp_q[$];

   // ---------------- reference model ----------------
   // Sequence described by its schedule: t = cycles since the start cycle.
   bit m_act      = 1'b0;
   int m_t        = 0;
   int m_P        = 0;
   int m_B        = 0;
   int m_first    = 0;   // t of first sp
   int m_end      = -1;  // t of done, -1 when continuous
   int m_idx_hold = 0;   // strobe_idx while idle / during clear

   function automatic int cnt_at(int t);
      int n;
      if (t <= m_first) return 0;
      n = (t - 1 - m_first) / (m_P + 1) + 1;
      if (m_B != 0 && n > m_B) n = m_B;
      return n % 256;
   endfunction

   function automatic bit sp_at(int t);
      if (t < m_first) return 1'b0;
      if ((t - m_first) % (m_P + 1) != 0) return 1'b0;
      return (m_B == 0) || ((t - m_first) / (m_P + 1) < m_B);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic compare_outputs();
      logic e_sp, e_cd, e_busy, e_done;
      int   e_idx;
      if (!m_act) begin
         e_sp = 0; e_cd = 0; e_busy = 0; e_done = 0; e_idx = m_idx_hold;
      end else begin
         e_sp   = sp_at(m_t);
         e_cd   = (m_t == 1);
         e_busy = 1'b1;
         e_done = (m_t == m_end);
         e_idx  = (m_t == 1) ? m_idx_hold : cnt_at(m_t);
      end
      check("sp",   {31'd0, sp},   {31'd0, e_sp});
      check("cd",   {31'd0, cd},   {31'd0, e_cd});
      check("busy", {31'd0, busy}, {31'd0, e_busy});
      check("done", {31'd0, done}, {31'd0, e_done});
      check("idx",  {24'd0, strobe_idx}, e_idx);
   endtask

   task automatic model_update(input bit r, input bit s, input bit p,
                               input int per, input int bur, input int ph);
      if (r) begin
         m_act = 0; m_idx_hold = 0;
      end else if (!m_act) begin
         if (s && !p) begin
            m_act = 1; m_t = 1; m_P = per; m_B = bur;
`ifdef CE_STROBE_PHASE_EN
            m_first = 2 + ph;
`else
            m_first = 2 + per;
`endif
            m_end = (bur == 0) ? -1 : m_first + (bur - 1) * (per + 1) + 1;
         end
      end else if (m_t == m_end) begin
         m_act = 0; m_idx_hold = cnt_at(m_t + 1);
      end else if (p) begin
         m_act = 0; m_idx_hold = cnt_at(m_t + 1);
      end else begin
         m_t++;
      end
   endtask

   // ---------------- driver ----------------
   task automatic run_cycle(input bit r, input bit s, input bit p,
                            input int per, input int bur, input int ph);
      rst = r; start = s; stop = p;
      cfg_period = per[CNT_W-1:0];
      cfg_burst  = bur[BURST_W-1:0];
      cfg_phase  = ph[CNT_W-1:0];
      @(negedge clk);
      compare_outputs();
      if (sp === 1'b1) sp_log.push_back(cyc);
      model_update(r, s, p, per, bur, ph);
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic check_log(input string tag);
      check({tag, "_cnt"}, sp_log.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < sp_log.size()) check(tag, sp_log[i], exp_q[i]);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1; start = 0; stop = 0; cfg_period = '0; cfg_burst = '0; cfg_phase = '0;
      @(posedge clk); @(posedge clk); #1;
      run_cycle(1, 0, 0, 0, 0, 0);            // reset state
      repeat (2) run_cycle(0, 0, 0, 0, 0, 0);

`ifndef CE_STROBE_PHASE_EN
      // P=3 B=4
      cyc = 0; sp_log.delete();
      run_cycle(0, 1, 0, 3, 4, 0);
      repeat (21) run_cycle(0, 0, 0, 3, 4, 0);
      exp_q = '{5, 9, 13, 17}; check_log("t1_sp");

      // P=0 B=3
      cyc = 0; sp_log.delete();
      run_cycle(0, 1, 0, 0, 3, 0);
      repeat (7) run_cycle(0, 0, 0, 0, 3, 0);
      exp_q = '{2, 3, 4}; check_log("t2_sp");

      // P=1 B=0, stop at cycle 10
      cyc = 0; sp_log.delete();
      run_cycle(0, 1, 0, 1, 0, 0);
      repeat (9) run_cycle(0, 0, 0, 1, 0, 0);
      run_cycle(0, 0, 1, 1, 0, 0);
      repeat (4) run_cycle(0, 0, 0, 1, 0, 0);
      exp_q = '{3, 5, 7, 9}; check_log("t3_sp");

      // start at 7, cfg_period changes to 9 afterwards
      cyc = 0; sp_log.delete();
      repeat (7) run_cycle(0, 0, 0, 3, 4, 0);
      run_cycle(0, 1, 0, 3, 4, 0);
      repeat (22) run_cycle(0, 0, 0, 9, 4, 0);
      exp_q = '{12, 16, 20, 24}; check_log("t4_sp");

      // rst at 6, restart at 8
      cyc = 0; sp_log.delete();
      run_cycle(0, 1, 0, 3, 4, 0);
      repeat (5) run_cycle(0, 0, 0, 3, 4, 0);
      run_cycle(1, 0, 0, 3, 4, 0);
      run_cycle(0, 0, 0, 3, 4, 0);
      run_cycle(0, 1, 0, 3, 4, 0);
      repeat (7) run_cycle(0, 0, 0, 3, 4, 0);
      exp_q = '{5, 13}; check_log("t5_sp");

      // start and stop together in IDLE: stays idle
      cyc = 0; sp_log.delete();
      run_cycle(0, 1, 1, 0, 1, 0);
      repeat (4) run_cycle(0, 0, 0, 0, 1, 0);
      exp_q = {}; check_log("t6_sp");
`else
      // phase=0 P=4 B=2
      cyc = 0; sp_log.delete();
      run_cycle(0, 1, 0, 4, 2, 0);
      repeat (10) run_cycle(0, 0, 0, 4, 2, 0);
      exp_q = '{2, 7}; check_log("tp_sp");

      // phase=3 P=1 B=3
      cyc = 0; sp_log.delete();
      run_cycle(0, 1, 0, 1, 3, 3);
      repeat (12) run_cycle(0, 0, 0, 1, 3, 3);
      exp_q = '{5, 7, 9}; check_log("tp2_sp");
`endif

      // randomized traffic checked cycle by cycle against the model
      for (int n = 0; n < 40; n++) begin
         int len;
         len = $urandom_range(60, 10);
         for (int c = 0; c < len; c++) begin
            bit r, s, p;
            r = ($urandom_range(79, 0) == 0);
            s = ($urandom_range(3, 0) == 0);
            p = ($urandom_range(24, 0) == 0);
            run_cycle(r, s, p, $urandom_range(6, 0), $urandom_range(5, 0),
                      $urandom_range(5, 0));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
